// File: rtl/nor2_b_pkg.sv
// Shared constants and helpers for the nor2_b_unit registered NOR stage.
package nor2_b_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 16;

    // Width needed to hold a ones count of 0..w inclusive.
    function automatic int ones_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/nor2_b_popcount.sv
// Purely combinational ones counter over a WIDTH-bit vector.
module nor2_b_popcount #(
    parameter int WIDTH = 1,
    parameter int OUT_W = 1
) (
    input  logic [WIDTH-1:0] data,
    output logic [OUT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + OUT_W'(data[i]);
        end
    end

endmodule

// File: rtl/nor2_b_unit.sv
// WIDTH-lane registered NOR with ones statistics and a saturating evaluation counter.
// Defining NOR2_B_COMB_OUT_EN adds o_comb, the unregistered NOR result.
module nor2_b_unit
    import nor2_b_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W,
    localparam int ONES_W = ones_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    output logic [WIDTH-1:0]  o,
    output logic [ONES_W-1:0] o_ones,
    output logic              o_all_ones,
    output logic [CNT_W-1:0]  eval_count
`ifdef NOR2_B_COMB_OUT_EN
    ,
    output logic [WIDTH-1:0]  o_comb
`endif
);

    // Handshake: in_valid qualifies a/b at a rising edge and is always accepted
    // (no ready); out_valid pulses high for the one cycle after each acceptance.
    logic [WIDTH-1:0]  nor_res;
    logic [ONES_W-1:0] ones_comb;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  o_q, o_d;
    logic [ONES_W-1:0] o_ones_q, o_ones_d;
    logic              o_all_ones_q, o_all_ones_d;
    logic [CNT_W-1:0]  eval_count_q, eval_count_d;

    assign nor_res = ~(a | b);

    nor2_b_popcount #(
        .WIDTH (WIDTH),
        .OUT_W (ONES_W)
    ) u_popcount (
        .data  (nor_res),
        .count (ones_comb)
    );

    always_comb begin
        out_valid_d  = in_valid;
        o_d          = o_q;
        o_ones_d     = o_ones_q;
        o_all_ones_d = o_all_ones_q;
        eval_count_d = eval_count_q;
        if (in_valid) begin
            // All three result fields load together so they never disagree.
            o_d          = nor_res;
            o_ones_d     = ones_comb;
            o_all_ones_d = &nor_res;
            if (eval_count_q != {CNT_W{1'b1}}) begin
                eval_count_d = eval_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            o_q          <= '0;
            o_ones_q     <= '0;
            o_all_ones_q <= 1'b0;
            eval_count_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            o_q          <= o_d;
            o_ones_q     <= o_ones_d;
            o_all_ones_q <= o_all_ones_d;
            eval_count_q <= eval_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign o          = o_q;
    assign o_ones     = o_ones_q;
    assign o_all_ones = o_all_ones_q;
    assign eval_count = eval_count_q;

`ifdef NOR2_B_COMB_OUT_EN
    assign o_comb = nor_res;
`endif

endmodule

// File: tb/tb_nor2_b_unit.sv
// Directed bench for nor2_b_unit: scalar, 8-lane and 2-bit-counter instances.
module tb_nor2_b_unit;
    import nor2_b_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Scalar instance, default counter width
    logic        s_v = 1'b0;
    logic [0:0]  s_a = '0, s_b = '0;
    logic        s_ov, s_all;
    logic [0:0]  s_o;
    logic [ones_w(1)-1:0] s_ones;
    logic [15:0] s_cnt;

    // 8-lane instance
    logic        w_v = 1'b0;
    logic [7:0]  w_a = '0, w_b = '0;
    logic        w_ov, w_all;
    logic [7:0]  w_o;
    logic [ones_w(8)-1:0] w_ones;
    logic [15:0] w_cnt;

    // Scalar instance with a 2-bit counter
    logic        c_v = 1'b0;
    logic [0:0]  c_a = '0, c_b = '0;
    logic        c_ov, c_all;
    logic [0:0]  c_o;
    logic [ones_w(1)-1:0] c_ones;
    logic [1:0]  c_cnt;

`ifdef NOR2_B_COMB_OUT_EN
    logic [0:0]  s_oc;
    logic [7:0]  w_oc;
    logic [0:0]  c_oc;
`endif

    nor2_b_unit #(.WIDTH(1), .CNT_W(16)) u_s (
        .clk(clk), .rst(rst), .in_valid(s_v), .a(s_a), .b(s_b),
        .out_valid(s_ov), .o(s_o), .o_ones(s_ones), .o_all_ones(s_all),
        .eval_count(s_cnt)
`ifdef NOR2_B_COMB_OUT_EN
        , .o_comb(s_oc)
`endif
    );

    nor2_b_unit #(.WIDTH(8), .CNT_W(16)) u_w (
        .clk(clk), .rst(rst), .in_valid(w_v), .a(w_a), .b(w_b),
        .out_valid(w_ov), .o(w_o), .o_ones(w_ones), .o_all_ones(w_all),
        .eval_count(w_cnt)
`ifdef NOR2_B_COMB_OUT_EN
        , .o_comb(w_oc)
`endif
    );

    nor2_b_unit #(.WIDTH(1), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_v), .a(c_a), .b(c_b),
        .out_valid(c_ov), .o(c_o), .o_ones(c_ones), .o_all_ones(c_all),
        .eval_count(c_cnt)
`ifdef NOR2_B_COMB_OUT_EN
        , .o_comb(c_oc)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset, then idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_o",     32'(s_o),   32'h0);
            check("idle_ov",    32'(s_ov),  32'h0);
            check("idle_cnt",   32'(s_cnt), 32'h0);
        end
        check("idle_ones",  32'(s_ones), 32'h0);
        check("idle_all",   32'(s_all),  32'h0);
        check("idle_w_cnt", 32'(w_cnt),  32'h0);

        // Scalar truth table
        s_v = 1'b1; s_a = 1'b0; s_b = 1'b0;
        tick();
        check("tt00_o",    32'(s_o),    32'h1);
        check("tt00_ov",   32'(s_ov),   32'h1);
        check("tt00_ones", 32'(s_ones), 32'h1);
        check("tt00_all",  32'(s_all),  32'h1);
        check("tt00_cnt",  32'(s_cnt),  32'd1);
        s_a = 1'b0; s_b = 1'b1;
        tick();
        check("tt01_o",    32'(s_o),    32'h0);
        check("tt01_ones", 32'(s_ones), 32'h0);
        check("tt01_all",  32'(s_all),  32'h0);
        check("tt01_cnt",  32'(s_cnt),  32'd2);
        s_a = 1'b1; s_b = 1'b0;
        tick();
        check("tt10_o",    32'(s_o),    32'h0);
        check("tt10_ov",   32'(s_ov),   32'h1);
        check("tt10_cnt",  32'(s_cnt),  32'd3);
        s_a = 1'b1; s_b = 1'b1;
        tick();
        check("tt11_o",    32'(s_o),    32'h0);
        check("tt11_cnt",  32'(s_cnt),  32'd4);

        // Hold: valid 0/0 then idle with 1/1 on the inputs
        s_a = 1'b0; s_b = 1'b0;
        tick();
        check("hold_load_o",   32'(s_o),   32'h1);
        check("hold_load_cnt", 32'(s_cnt), 32'd5);
        s_v = 1'b0; s_a = 1'b1; s_b = 1'b1;
        tick();
        check("hold_o",    32'(s_o),    32'h1);
        check("hold_ov",   32'(s_ov),   32'h0);
        check("hold_ones", 32'(s_ones), 32'h1);
        check("hold_all",  32'(s_all),  32'h1);
        check("hold_cnt",  32'(s_cnt),  32'd5);

        // 8-lane statistics
        w_v = 1'b1; w_a = 8'h00; w_b = 8'h00;
        tick();
        check("w8_zero_o",    32'(w_o),    32'hFF);
        check("w8_zero_ones", 32'(w_ones), 32'd8);
        check("w8_zero_all",  32'(w_all),  32'h1);
        check("w8_zero_ov",   32'(w_ov),   32'h1);
        w_a = 8'h0F; w_b = 8'h30;
        tick();
        check("w8_mix_o",    32'(w_o),    32'hC0);
        check("w8_mix_ones", 32'(w_ones), 32'd2);
        check("w8_mix_all",  32'(w_all),  32'h0);
        check("w8_mix_cnt",  32'(w_cnt),  32'd2);
        w_v = 1'b0;
        tick();
        check("w8_idle_ov", 32'(w_ov), 32'h0);
        check("w8_idle_o",  32'(w_o),  32'hC0);

        // Counter saturation at 3
        c_v = 1'b1;
        tick(); check("sat_1", 32'(c_cnt), 32'd1);
        tick(); check("sat_2", 32'(c_cnt), 32'd2);
        tick(); check("sat_3", 32'(c_cnt), 32'd3);
        tick(); check("sat_4", 32'(c_cnt), 32'd3);
        tick(); check("sat_5", 32'(c_cnt), 32'd3);
        c_v = 1'b0;

        // Reset mid-stream wins over a valid 0/0 evaluation
        rst = 1'b1; s_v = 1'b1; s_a = 1'b0; s_b = 1'b0;
        tick();
        check("rst_o",     32'(s_o),    32'h0);
        check("rst_ov",    32'(s_ov),   32'h0);
        check("rst_cnt",   32'(s_cnt),  32'h0);
        check("rst_ones",  32'(s_ones), 32'h0);
        check("rst_c_cnt", 32'(c_cnt),  32'h0);

`ifdef NOR2_B_COMB_OUT_EN
        // Combinational output while still in reset
        s_v = 1'b0; s_a = 1'b0; s_b = 1'b0;
        w_a = 8'h0F; w_b = 8'h30;
        #1;
        check("comb_s_00", 32'(s_oc), 32'h1);
        check("comb_w",    32'(w_oc), 32'hC0);
        s_a = 1'b1;
        #1;
        check("comb_s_10", 32'(s_oc), 32'h0);
`endif
        s_v = 1'b0;
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
